// File: rtl/ram_pkg.sv
// Shared definitions for the RAM block and its upstream write controller.
package ram_pkg;

  localparam int RAM_DW = 32;
  localparam int RAM_AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output.
// The pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          push_en;
  logic          pop_en;

  // Guard the strobes so a push into a full FIFO or a pop from an empty one is harmless.
  always_comb begin
    push_en = push && !full;
    pop_en  = pop && !empty;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    dout    = mem[rd_ptr[PW-1:0]];
  end

  // Advance the pointers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; its contents are meaningless until written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/ram_wr_ctrl.sv
// Upstream write stage for the RAM: buffers a valid/ready word stream and
// writes one burst of consecutive addresses per start pulse, then pulses done.
module ram_wr_ctrl
  import ram_pkg::*;
#(
  parameter int DW    = RAM_DW,
  parameter int AW    = RAM_AW,
  parameter int DEPTH = 4,
  parameter int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          ram_stall,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          busy,
  output logic          done
);

  wr_state_e     state;
  wr_state_e     state_nxt;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] acc_cnt;
  logic [LW-1:0] wr_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          accept;
  logic          pop;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake and pop decisions; the FIFO only holds words while a burst is active.
  always_comb begin
    in_ready = (state == RUN) && !fifo_full && (acc_cnt < len_q);
    accept   = in_valid && in_ready;
    pop      = !fifo_empty && !ram_stall && ((state == RUN) || (state == DRAIN));
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        if (acc_cnt == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt == len_q) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Burst parameters, accept/write counters and the wrapping address generator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        addr_q  <= base_addr;
        len_q   <= length;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end
    end else begin
      if (accept) acc_cnt <= acc_cnt + LW'(1);
      if (pop) begin
        addr_q <= addr_q + AW'(1);
        wr_cnt <= wr_cnt + LW'(1);
      end
    end
  end

  // Registered RAM write port; address and data hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= pop;
      if (pop) begin
        ram_addr  <= addr_q;
        ram_wdata <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// Directed testbench for ram_wr_ctrl: table-driven bursts plus hand-written
// stall, zero-length, ignored-start, reset and bubble sequences.
module tb_ram_wr_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        ram_stall;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        done;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [31:0] data0;
    logic [7:0]  exp_last_addr;
  } vec_t;

  wr_t  writes[$];
  vec_t tbl[4];
  int   checks;
  int   errors;
  int   cyc;
  int   done_cnt;
  int   done_cyc;

  ram_wr_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_stall (ram_stall),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time writes and done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && ram_we) writes.push_back('{addr: ram_addr, data: ram_wdata, cyc: cyc});
    if (rst && done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue a one-cycle start pulse with the given burst parameters.
  task automatic applyStimulus(input logic [7:0] base, input logic [8:0] len);
    start     = 1'b1;
    base_addr = base;
    length    = len;
    @(negedge clk); #1;
    start     = 1'b0;
  endtask

  // Offer words until count are accepted or the cycle budget runs out.
  task automatic feedWords(input logic [31:0] data0, input int first, input int count,
                           input bit bubble, input int max_cycles, output int sent);
    bit acc;
    sent = 0;
    for (int k = 0; k < max_cycles && sent < count; k++) begin
      in_valid = bubble ? (k % 2 == 0) : 1'b1;
      in_data  = data0 + 32'(first + sent);
      #1;
      acc = in_valid && in_ready;
      @(negedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int target, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput({name, "_done_timeout"}, 64'(done_cnt >= target), 64'd1);
  endtask

  initial begin
    int sent;
    int sent2;
    int base_done;
    int n;

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    done_cnt  = 0;
    done_cyc  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    ram_stall = 1'b0;

    tbl[0] = '{base: 8'h10, len: 9'd4,  data0: 32'hA0,   exp_last_addr: 8'h13};
    tbl[1] = '{base: 8'hFE, len: 9'd4,  data0: 32'hB0,   exp_last_addr: 8'h01};
    tbl[2] = '{base: 8'h00, len: 9'd1,  data0: 32'h55,   exp_last_addr: 8'h00};
    tbl[3] = '{base: 8'hF0, len: 9'd17, data0: 32'h1000, exp_last_addr: 8'h00};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ram_we",    64'(ram_we),    64'd0);
    checkOutput("rst_ram_addr",  64'(ram_addr),  64'd0);
    checkOutput("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_done",      64'(done),      64'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Table-driven bursts with in_valid held high and no stall.
    for (int v = 0; v < 4; v++) begin
      writes.delete();
      base_done = done_cnt;
      applyStimulus(tbl[v].base, tbl[v].len);
      checkOutput($sformatf("v%0d_busy_run", v), 64'(busy), 64'd1);
      feedWords(tbl[v].data0, 0, int'(tbl[v].len), 1'b0, 100, sent);
      checkOutput($sformatf("v%0d_sent", v), 64'(sent), 64'(tbl[v].len));
      waitDone(base_done + 1, $sformatf("v%0d", v));
      @(negedge clk); #1;
      checkOutput($sformatf("v%0d_busy_after", v), 64'(busy), 64'd0);
      checkOutput($sformatf("v%0d_done_once", v), 64'(done_cnt - base_done), 64'd1);
      checkOutput($sformatf("v%0d_nwrites", v), 64'(writes.size()), 64'(tbl[v].len));
      if (writes.size() == int'(tbl[v].len)) begin
        for (int i = 0; i < writes.size(); i++) begin
          checkOutput($sformatf("v%0d_addr%0d", v, i), 64'(writes[i].addr), 64'(8'(tbl[v].base + 8'(i))));
          checkOutput($sformatf("v%0d_data%0d", v, i), 64'(writes[i].data), 64'(tbl[v].data0 + 32'(i)));
          if (i > 0)
            checkOutput($sformatf("v%0d_b2b%0d", v, i), 64'(writes[i].cyc - writes[i-1].cyc), 64'd1);
        end
        checkOutput($sformatf("v%0d_last_addr", v), 64'(writes[writes.size()-1].addr), 64'(tbl[v].exp_last_addr));
        checkOutput($sformatf("v%0d_done_lat", v), 64'(done_cyc - writes[writes.size()-1].cyc), 64'd1);
      end
    end

    // Stall and backpressure: FIFO fills to four words, then in_ready drops.
    writes.delete();
    base_done = done_cnt;
    ram_stall = 1'b1;
    applyStimulus(8'h50, 9'd8);
    feedWords(32'h200, 0, 8, 1'b0, 10, sent);
    checkOutput("stall_accepts", 64'(sent), 64'd4);
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_no_we", 64'(writes.size()), 64'd0);
    ram_stall = 1'b0;
    feedWords(32'h200, sent, 8 - sent, 1'b0, 50, sent2);
    checkOutput("stall_rest", 64'(sent + sent2), 64'd8);
    waitDone(base_done + 1, "stall");
    @(negedge clk); #1;
    checkOutput("stall_done_once", 64'(done_cnt - base_done), 64'd1);
    checkOutput("stall_nwrites", 64'(writes.size()), 64'd8);
    n = (writes.size() < 8) ? writes.size() : 8;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("stall_addr%0d", i), 64'(writes[i].addr), 64'(8'h50 + 8'(i)));
      checkOutput($sformatf("stall_data%0d", i), 64'(writes[i].data), 64'(32'h200 + 32'(i)));
    end

    // Zero length: done one cycle after start, no writes.
    writes.delete();
    base_done = done_cnt;
    applyStimulus(8'h33, 9'd0);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    checkOutput("zero_done_drop", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("zero_no_we", 64'(writes.size()), 64'd0);
    checkOutput("zero_done_once", 64'(done_cnt - base_done), 64'd1);

    // A second start in the middle of a burst is ignored.
    writes.delete();
    base_done = done_cnt;
    applyStimulus(8'h20, 9'd6);
    feedWords(32'h300, 0, 2, 1'b0, 20, sent);
    applyStimulus(8'h80, 9'd2);
    feedWords(32'h300, sent, 6 - sent, 1'b0, 40, sent2);
    waitDone(base_done + 1, "ign");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("ign_done_once", 64'(done_cnt - base_done), 64'd1);
    checkOutput("ign_nwrites", 64'(writes.size()), 64'd6);
    n = (writes.size() < 6) ? writes.size() : 6;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("ign_addr%0d", i), 64'(writes[i].addr), 64'(8'h20 + 8'(i)));
      checkOutput($sformatf("ign_data%0d", i), 64'(writes[i].data), 64'(32'h300 + 32'(i)));
    end

    // Asynchronous reset in the middle of a burst.
    writes.delete();
    applyStimulus(8'h30, 9'd6);
    feedWords(32'h400, 0, 3, 1'b0, 20, sent);
    @(negedge clk); #1;
    checkOutput("arst_pre_writes", 64'(writes.size()), 64'd3);
    checkOutput("arst_pre_we", 64'(ram_we), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst_we",       64'(ram_we),   64'd0);
    checkOutput("arst_busy",     64'(busy),     64'd0);
    checkOutput("arst_done",     64'(done),     64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    writes.delete();
    base_done = done_cnt;
    applyStimulus(8'h40, 9'd2);
    feedWords(32'hD0, 0, 2, 1'b0, 20, sent);
    waitDone(base_done + 1, "arst");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("arst_nwrites", 64'(writes.size()), 64'd2);
    n = (writes.size() < 2) ? writes.size() : 2;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("arst_addr%0d", i), 64'(writes[i].addr), 64'(8'h40 + 8'(i)));
      checkOutput($sformatf("arst_data%0d", i), 64'(writes[i].data), 64'(32'hD0 + 32'(i)));
    end

    // Upstream bubbles: writes follow the input gaps.
    writes.delete();
    base_done = done_cnt;
    applyStimulus(8'h60, 9'd5);
    feedWords(32'hE0, 0, 5, 1'b1, 40, sent);
    waitDone(base_done + 1, "bub");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("bub_nwrites", 64'(writes.size()), 64'd5);
    n = (writes.size() < 5) ? writes.size() : 5;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("bub_addr%0d", i), 64'(writes[i].addr), 64'(8'h60 + 8'(i)));
      checkOutput($sformatf("bub_data%0d", i), 64'(writes[i].data), 64'(32'hE0 + 32'(i)));
      if (i > 0)
        checkOutput($sformatf("bub_gap%0d", i), 64'(writes[i].cyc - writes[i-1].cyc), 64'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_wr_ctrl.md
Name: ram_wr_ctrl

Overview:
Upstream write stage for the ram block: accepts a valid/ready stream of 32-bit words and writes them into consecutive RAM locations. Words are buffered in a small FIFO, and writing starts at a programmed base address. Runs one burst of a programmed length per start pulse, then reports done. Absorbs RAM-side stalls without dropping data.

Parameters:
DW, 32, data word width (matches ram in/out width)
AW, 8, RAM address width; the address wraps modulo 2^AW
DEPTH, 4, internal FIFO depth in words (power of 2, >=2)
LW, 9, burst length counter width (AW+1, so a full 2^AW burst is legal)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a burst; honoured only in IDLE
base_addr  in  AW  first RAM address of the burst; sampled on start
length  in  LW  number of words in the burst; sampled on start
in_valid  in  1  upstream word valid
in_data  in  DW  upstream word
in_ready  out  1  block can accept in_data this cycle
ram_stall  in  1  RAM side cannot take a write this cycle
ram_we  out  1  write strobe, one cycle per word
ram_addr  out  AW  write address
ram_wdata  out  DW  write data
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the last word of the burst is written

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; FIFO empty; counters=0. ram_we=0, ram_addr=0, ram_wdata=0, in_ready=0, busy=0, done=0. Reset mid-burst discards buffered words, and no further writes occur.
- Handshake: a word is accepted on a rising edge when in_valid && in_ready. in_ready is combinational: state==RUN && !fifo_full && acc_cnt<len_q. in_data must stay stable while in_valid && !in_ready.
- States:
  - IDLE: on start, latch base_addr->addr_q and length->len_q, clear acc_cnt and wr_cnt. If length==0, go to DONE; otherwise go to RUN.
  - RUN: accept words; go to DRAIN when acc_cnt reaches len_q.
  - DRAIN: in_ready=0; keep writing from the FIFO; go to DONE when wr_cnt reaches len_q.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Write side:
  - Each cycle with FIFO non-empty && !ram_stall, pop one word and register it as ram_we=1, ram_wdata=word, ram_addr=addr_q.
  - Then addr_q<=addr_q+1 (wraps 2^AW-1 -> 0) and wr_cnt++.
  - ram_we=0 on all other cycles; ram_addr/ram_wdata hold their last values.
- Latency: with the FIFO empty and no stall, a word accepted at edge N appears on ram_we/ram_wdata after edge N+1.
- Throughput: 1 word/cycle sustained.
- Stall: ram_stall=1 freezes pops. The FIFO fills to DEPTH, then in_ready drops. Accepted words are never lost or reordered.
- Simultaneous push and pop on a full FIFO is not allowed, because in_ready=0 when full. Push and pop on a non-full FIFO in the same cycle leaves the occupancy unchanged.
- done rises in the cycle after the final ram_we. For length==0, done rises 1 cycle after start with no ram_we.
- busy=1 exactly in RUN and DRAIN.
- Counters are LW bits wide. length > 2^AW is legal: addresses wrap and overwrite earlier locations.

Decomposition:
- Shared package ram_pkg holds the state enum (IDLE, RUN, DRAIN, DONE) and the default DW/AW constants used by both ram and ram_wr_ctrl.
- One sub-module, sync_fifo: parameters DW and DEPTH; ports push, pop, din, dout, full, empty, with the same clk/rst convention. It implements the read/write pointers with an extra wrap bit.
- The FSM, counters and address generator stay in ram_wr_ctrl.

Test Plan:
- Basic burst: base=0x10, length=4, data 0xA0..0xA3 with in_valid held high, no stall. Expect 4 consecutive ram_we at addr 0x10..0x13 with data 0xA0..0xA3, done one cycle after the last write, busy low after done.
- Wrap: base=0xFE, length=4. Expect writes to 0xFE, 0xFF, 0x00, 0x01 in order.
- Stall/backpressure: length=8, ram_stall=1 for 10 cycles from the first accept. Expect in_ready=0 after exactly 4 accepts and no ram_we during the stall. After release, all 8 words are written in order and done fires once.
- Zero length and ignored start: start with length=0 gives done one cycle later with no ram_we. A second start during a length=6 burst changes neither the address nor the count.
- Async reset mid-burst: drop rst after 3 of 6 writes. ram_we, busy, done and in_ready go to 0 immediately without a clock edge. After release, a new burst base=0x40, length=2 writes only the new data.
- Upstream bubbles: length=5 with in_valid toggling 1,0,1,0… Expect exactly 5 writes at consecutive addresses, with ram_we gaps matching the input gaps.
